repeat_pulse_gen: RTL and testbench
===================================

Name: repeat_pulse_gen

Overview:
- Multi-channel press-to-pulse generator for the counter datapath.
- Converts raw per-digit trigger levels into single-cycle increment pulses tagged with the originating channel(s).
- Held channels auto-repeat: a long initial delay, then a repeat period, with optional acceleration.
- Each increment is followed by a delayed refresh pulse for the display path, then a debounce lockout window.

Parameters:
- CHANNELS, 8, number of trigger inputs.
- CNT_WIDTH, 20, timer width; must hold max(INIT_DELAY, REPEAT_PERIOD, REFRESH_DELAY, LOCKOUT).
- INIT_DELAY, 1000000, HOLD cycles before the first auto-repeat (>=1).
- REPEAT_PERIOD, 333333, HOLD cycles between later repeats (>=2).
- REFRESH_DELAY, 10, cycles from inc_pulse to ref_pulse (>=1).
- LOCKOUT, 8192, debounce cycles after ref_pulse (>=1).
- ACCEL_STEPS, 4, repeats before acceleration applies (1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- trigger  in  CHANNELS  raw press levels, already synchronised, 1 = pressed
- enable  in  1  1 = pulse generation allowed
- accel_en  in  1  1 = halve the repeat period after ACCEL_STEPS repeats
- inc_pulse  out  1  one-cycle increment strobe
- inc_chan  out  CHANNELS  channels causing this increment; valid only while inc_pulse=1, otherwise 0
- ref_pulse  out  1  one-cycle refresh strobe
- busy  out  1  1 while in CALC or LOCK

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; timer, rep_cnt, prev, inc_pulse, inc_chan and ref_pulse all 0; busy=0.
  - A trigger held through reset release counts as a new press.
- All outputs are registered. busy is decoded from the state register.
- Definitions: rise = trigger & ~prev; held = trigger & prev.
- IDLE:
  - prev<=trigger every cycle.
  - If enable and rise!=0: inc_pulse<=1, inc_chan<=rise, timer<=0, rep_cnt<=0, go to CALC.
- CALC:
  - prev frozen. timer increments.
  - When timer==REFRESH_DELAY-1: ref_pulse<=1, timer<=0, go to LOCK.
  - ref_pulse therefore occurs exactly REFRESH_DELAY cycles after inc_pulse.
- LOCK:
  - prev frozen; trigger ignored.
  - When timer==LOCKOUT-1: timer<=0, go to HOLD.
- HOLD (evaluated in priority order):
  - prev<=trigger every cycle.
  - 1) enable=0: go to IDLE, timer<=0.
  - 2) rise!=0: immediate press, handled as in IDLE. rep_cnt<=0, inc_chan=rise only. This wins over a simultaneous repeat expiry.
  - 3) held==0: go to IDLE, timer<=0.
  - 4) Otherwise timer increments against threshold thr:
    - thr = INIT_DELAY if rep_cnt==0;
    - thr = REPEAT_PERIOD>>1 if accel_en and rep_cnt>=ACCEL_STEPS;
    - thr = REPEAT_PERIOD otherwise.
    - When timer==thr-1: inc_pulse<=1, inc_chan<=held, rep_cnt<=rep_cnt+1 (saturating at ACCEL_STEPS), timer<=0, go to CALC.
- Repeat spacing: pulse-to-pulse interval = REFRESH_DELAY + LOCKOUT + thr.
- A press arriving during CALC/LOCK is not lost. prev is frozen, so it appears as a rise on the first HOLD cycle and fires there.
- enable deasserting during CALC/LOCK: the in-flight ref_pulse and lockout still complete.
- In IDLE, held channels never auto-repeat; a re-press is required. This covers channels held across enable going 1.
- accel_en is sampled every HOLD cycle, so a mid-hold change takes effect on the next threshold compare.
- rst_n asserted mid-operation: outputs clear immediately; pending ref_pulse is dropped.

Test Plan:
Bench parameters: CHANNELS=4, INIT_DELAY=20, REPEAT_PERIOD=8, REFRESH_DELAY=3, LOCKOUT=5, ACCEL_STEPS=2.
- Tap: trigger=0010 for 2 cycles from IDLE -> one inc_pulse with inc_chan=0010; ref_pulse 3 cycles later; busy high 8 cycles; return to IDLE; no further pulses.
- Hold ch0 with accel_en=1 -> inc_pulse intervals 28, 16, 12, 12…; inc_chan=0001 each time; ref_pulse 3 cycles after each. Same with accel_en=0 -> intervals 28, 16, 16, 16.
- Hold ch0, press ch2 during LOCK -> inc_pulse on first HOLD cycle with inc_chan=0100; rep_cnt restarts, so next repeat comes after INIT_DELAY with inc_chan=0101.
- Rise coinciding with repeat expiry -> single inc_pulse, inc_chan = new channel only.
- rst_n low one cycle mid-CALC -> inc_pulse, ref_pulse, busy and inc_chan = 0 immediately, no ref_pulse follows; trigger=1000 held through reset release -> inc_pulse with inc_chan=1000 on the first active cycle.
- enable=0, press ch1 -> no pulses. Raise enable while ch1 held -> still none. Release and re-press -> pulse.

Source files
------------

// File: rtl/repeat_pulse_gen.sv
// Press-to-pulse generator: one increment strobe per press, auto-repeat while held,
// followed by a delayed refresh strobe and a debounce lockout.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  S_IDLE | waiting for a fresh press; held levels never repeat here
//  S_CALC | increment issued, counting down to the refresh strobe
//  S_LOCK | debounce lockout after refresh, inputs ignored
//  S_HOLD | watching held channels for repeat or new presses
module repeat_pulse_gen #(
    parameter int CHANNELS      = 8,
    parameter int CNT_WIDTH     = 20,
    parameter int INIT_DELAY    = 1000000,
    parameter int REPEAT_PERIOD = 333333,
    parameter int REFRESH_DELAY = 10,
    parameter int LOCKOUT       = 8192,
    parameter int ACCEL_STEPS   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] trigger_i,
    input  logic                enable_i,
    input  logic                accel_en_i,
    output logic                inc_pulse_o,
    output logic [CHANNELS-1:0] inc_chan_o,
    output logic                ref_pulse_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_LOCK = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] INIT_TC = CNT_WIDTH'(INIT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] REP_TC  = CNT_WIDTH'(REPEAT_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] ACC_TC  = CNT_WIDTH'((REPEAT_PERIOD >> 1) - 1);
    localparam logic [CNT_WIDTH-1:0] REF_TC  = CNT_WIDTH'(REFRESH_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] LOCK_TC = CNT_WIDTH'(LOCKOUT - 1);
    localparam logic [7:0]           ACC_N   = 8'(ACCEL_STEPS);

    state_t                state_q;
    logic [CNT_WIDTH-1:0]  timer_q;
    logic [7:0]            rep_cnt_q;
    logic [CHANNELS-1:0]   prev_q;
    logic                  inc_pulse_q;
    logic [CHANNELS-1:0]   inc_chan_q;
    logic                  ref_pulse_q;

    logic [CHANNELS-1:0]   rise;
    logic [CHANNELS-1:0]   held;
    logic [CNT_WIDTH-1:0]  thr_tc;
    logic [7:0]            rep_cnt_d;

    assign rise = trigger_i & ~prev_q;
    assign held = trigger_i & prev_q;

    // Terminal count for the current repeat; accel_en is re-evaluated every cycle.
    always_comb begin
        thr_tc = REP_TC;
        if (rep_cnt_q == 8'd0) begin
            thr_tc = INIT_TC;
        end else if (accel_en_i && (rep_cnt_q >= ACC_N)) begin
            thr_tc = ACC_TC;
        end
    end

    assign rep_cnt_d = (rep_cnt_q >= ACC_N) ? ACC_N : rep_cnt_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            rep_cnt_q   <= 8'd0;
            prev_q      <= '0;
            inc_pulse_q <= 1'b0;
            inc_chan_q  <= '0;
            ref_pulse_q <= 1'b0;
        end else begin
            inc_pulse_q <= 1'b0;
            inc_chan_q  <= '0;
            ref_pulse_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    prev_q <= trigger_i;
                    if (enable_i && (rise != '0)) begin
                        inc_pulse_q <= 1'b1;
                        inc_chan_q  <= rise;
                        timer_q     <= '0;
                        rep_cnt_q   <= 8'd0;
                        state_q     <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (timer_q == REF_TC) begin
                        ref_pulse_q <= 1'b1;
                        timer_q     <= '0;
                        state_q     <= S_LOCK;
                    end else begin
                        timer_q <= timer_q + CNT_WIDTH'(1);
                    end
                end
                S_LOCK: begin
                    if (timer_q == LOCK_TC) begin
                        timer_q <= '0;
                        state_q <= S_HOLD;
                    end else begin
                        timer_q <= timer_q + CNT_WIDTH'(1);
                    end
                end
                S_HOLD: begin
                    // prev was frozen through CALC/LOCK, so presses made then surface as rises here
                    prev_q <= trigger_i;
                    if (!enable_i) begin
                        timer_q <= '0;
                        state_q <= S_IDLE;
                    end else if (rise != '0) begin
                        inc_pulse_q <= 1'b1;
                        inc_chan_q  <= rise;
                        timer_q     <= '0;
                        rep_cnt_q   <= 8'd0;
                        state_q     <= S_CALC;
                    end else if (held == '0) begin
                        timer_q <= '0;
                        state_q <= S_IDLE;
                    end else if (timer_q == thr_tc) begin
                        inc_pulse_q <= 1'b1;
                        inc_chan_q  <= held;
                        rep_cnt_q   <= rep_cnt_d;
                        timer_q     <= '0;
                        state_q     <= S_CALC;
                    end else begin
                        timer_q <= timer_q + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    timer_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign inc_pulse_o = inc_pulse_q;
    assign inc_chan_o  = inc_chan_q;
    assign ref_pulse_o = ref_pulse_q;
    assign busy_o      = (state_q == S_CALC) || (state_q == S_LOCK);

endmodule

// File: tb/tb_repeat_pulse_gen.sv
// Bench for repeat_pulse_gen: timeline model checked every cycle, plus literal
// expectations on pulse spacing and channel tags for each directed scenario.
module tb_repeat_pulse_gen;

    localparam int CH = 4;
    localparam int CW = 8;
    localparam int ID = 20;
    localparam int RP = 8;
    localparam int RD = 3;
    localparam int LK = 5;
    localparam int AS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] trig = '0;
    logic          en = 1'b1;
    logic          acc = 1'b0;
    logic          inc;
    logic [CH-1:0] chan;
    logic          rf;
    logic          busy;

    repeat_pulse_gen #(
        .CHANNELS(CH), .CNT_WIDTH(CW), .INIT_DELAY(ID), .REPEAT_PERIOD(RP),
        .REFRESH_DELAY(RD), .LOCKOUT(LK), .ACCEL_STEPS(AS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trigger_i(trig), .enable_i(en), .accel_en_i(acc),
        .inc_pulse_o(inc), .inc_chan_o(chan), .ref_pulse_o(rf), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int ecnt     = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, ecnt);
    endtask

    // Timeline model: an increment at edge E makes the block busy for RD+LK cycles,
    // refreshes at E+RD, and starts watching held channels at edge E+RD+LK+1.
    bit            m_active = 0;
    int            m_inc_e  = 0;
    int            m_nrep   = 0;
    logic [CH-1:0] m_prev   = '0;
    logic          m_inc = 0, m_ref = 0, m_busy = 0;
    logic [CH-1:0] m_chan = '0;

    int obs_t[$];
    int obs_c[$];
    int ref_t[$];
    int busy_cnt = 0;

    function automatic int thr_now();
        if (m_nrep == 0) return ID;
        if (acc && m_nrep >= AS) return RP / 2;
        return RP;
    endfunction

    task automatic fire(input logic [CH-1:0] c, input int n);
        m_active = 1;
        m_inc_e  = ecnt;
        m_inc    = 1;
        m_chan   = c;
        m_nrep   = n;
    endtask

    always @(posedge clk) begin
        logic [CH-1:0] rise;
        logic [CH-1:0] held;
        int elapsed;
        ecnt++;
        if (!rst_n) begin
            m_active = 0; m_prev = '0; m_inc = 0; m_chan = '0; m_ref = 0; m_busy = 0;
        end else begin
            m_inc = 0; m_chan = '0; m_ref = 0;
            if (m_active && ecnt <= m_inc_e + RD + LK) begin
                if (ecnt == m_inc_e + RD) m_ref = 1;
            end else begin
                rise = trig & ~m_prev;
                held = trig & m_prev;
                if (!m_active) begin
                    if (en && rise != '0) fire(rise, 0);
                end else begin
                    elapsed = ecnt - (m_inc_e + RD + LK + 1);
                    if (!en) m_active = 0;
                    else if (rise != '0) fire(rise, 0);
                    else if (held == '0) m_active = 0;
                    else if (elapsed == thr_now() - 1)
                        fire(held, (m_nrep + 1 > AS) ? AS : m_nrep + 1);
                end
                m_prev = trig;
            end
            m_busy = m_active && (ecnt < m_inc_e + RD + LK);
        end
        #1;
        chk("inc_pulse", int'(inc), int'(m_inc));
        chk("inc_chan",  int'(chan), int'(m_chan));
        chk("ref_pulse", int'(rf), int'(m_ref));
        chk("busy",      int'(busy), int'(m_busy));
        if (inc) begin
            obs_t.push_back(ecnt);
            obs_c.push_back(int'(chan));
        end
        if (rf) ref_t.push_back(ecnt);
        if (busy) busy_cnt++;
    end

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        obs_t.delete();
        obs_c.delete();
        ref_t.delete();
        busy_cnt = 0;
    endtask

    task automatic check_train(input string nm, input int cnt, input int gaps[4],
                               input int chans[5]);
        chk({nm, "_count"}, obs_t.size(), cnt);
        chk({nm, "_refs"}, ref_t.size(), cnt);
        for (int i = 0; i < cnt; i++) begin
            if (obs_t.size() > i) chk($sformatf("%s_chan%0d", nm, i), obs_c[i], chans[i]);
            if (obs_t.size() > i && ref_t.size() > i)
                chk($sformatf("%s_refdly%0d", nm, i), ref_t[i] - obs_t[i], RD);
            if (i > 0 && obs_t.size() > i)
                chk($sformatf("%s_gap%0d", nm, i), obs_t[i] - obs_t[i-1], gaps[i-1]);
        end
    endtask

    int rel;

    initial begin
        rst_n = 1'b0; en = 1'b1; acc = 1'b0; trig = '0;
        negs(2);
        chk("rst_inc", int'(inc), 0);
        chk("rst_chan", int'(chan), 0);
        chk("rst_ref", int'(rf), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        negs(3);

        // Tap
        clear_log();
        trig = 4'b0010; negs(2); trig = '0; negs(40);
        check_train("tap", 1, '{0, 0, 0, 0}, '{2, 0, 0, 0, 0});
        chk("tap_busy_cycles", busy_cnt, RD + LK);

        // Hold ch0 with acceleration
        clear_log();
        acc = 1'b1; trig = 4'b0001; negs(75); trig = '0; negs(40);
        check_train("accel", 5, '{28, 16, 12, 12}, '{1, 1, 1, 1, 1});

        // Hold ch0 without acceleration
        clear_log();
        acc = 1'b0; trig = 4'b0001; negs(80); trig = '0; negs(40);
        check_train("noaccel", 5, '{28, 16, 16, 16}, '{1, 1, 1, 1, 1});

        // Press ch2 during lockout while ch0 is held
        clear_log();
        trig = 4'b0001; negs(6); trig = 4'b0101; negs(39); trig = '0; negs(40);
        check_train("lockpress", 3, '{9, 28, 0, 0}, '{1, 4, 5, 0, 0});

        // New press coincides with the initial repeat expiry
        clear_log();
        trig = 4'b0001; negs(28); trig = 4'b1001; negs(12); trig = '0; negs(40);
        check_train("collide", 2, '{28, 0, 0, 0}, '{1, 8, 0, 0, 0});

        // Reset mid-CALC, with ch3 held through release
        trig = 4'b0010; negs(1);
        chk("prerst_inc", int'(inc), 1);
        trig = 4'b1000; rst_n = 1'b0; #1;
        chk("midrst_inc", int'(inc), 0);
        chk("midrst_chan", int'(chan), 0);
        chk("midrst_ref", int'(rf), 0);
        chk("midrst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rel = ecnt;
        clear_log();
        negs(20); trig = '0; negs(40);
        check_train("postrst", 1, '{0, 0, 0, 0}, '{8, 0, 0, 0, 0});
        if (obs_t.size() > 0) chk("postrst_first_edge", obs_t[0], rel + 1);

        // Enable gating: held across enable rising does not fire; re-press does
        clear_log();
        en = 1'b0; trig = 4'b0010; negs(10);
        en = 1'b1; negs(30);
        chk("en_held_count", obs_t.size(), 0);
        trig = '0; negs(3); trig = 4'b0010; negs(3); trig = '0; negs(40);
        check_train("repress", 1, '{0, 0, 0, 0}, '{2, 0, 0, 0, 0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
